mem_dump_ctrl: RTL and testbench

- Synthesizable memory-dump engine. It streams byte contents of up to NCH on-chip memories (for example instruction and data memory) over a valid/ready byte stream, tagging each byte with its channel and address.
- It replaces testbench-only file dumps with an in-hardware readout that an external host or UART bridge can consume.
- It sits beside the processor's memories on a dedicated synchronous read port.

---
 rtl/mem_dump_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dump_ctrl
//   Streams the byte contents of up to NCH on-chip memories over a
//   valid/ready byte stream. Each byte carries its channel index and address.
//   Channels are dumped in ascending index order, each over the same window
//   of eff_len = min(length, DEPTH) locations starting at base_addr, with the
//   address wrapping modulo DEPTH.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              one-cycle dump request, honoured only when idle
//   abort              cancels a dump in progress (no done pulse)
//   ch_mask            channel select, latched on accepted start
//   base_addr          first address, latched on accepted start
//   length             bytes per channel, latched (clamped) on accepted start
//   mem_rd_en          one-hot read strobe to the active channel
//   mem_addr           shared read address
//   mem_rd_data        per-channel read data, valid the cycle after mem_rd_en
//   out_valid/out_ready  byte stream handshake
//   out_data/out_ch/out_addr/out_last  byte, channel, address, final-byte flag
//   busy               high whenever a dump (or its completion) is in progress
//   done               one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module mem_dump_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int NCH    = 2,
    parameter int CH_W   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NCH-1:0]        ch_mask,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
    output logic [NCH-1:0]        mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [NCH*DATA_W-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LOAD,
        SEND,
        FIN
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] OFF_ONE = ADDR_W'(1);

    state_t state, state_d;

    // Latched configuration and walk position
    logic [NCH-1:0]    mask_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [CH_W-1:0]   ch_q;
    logic [ADDR_W-1:0] off_q;

    logic [ADDR_W:0]   eff_len;
    logic [CH_W-1:0]   first_ch;
    logic [CH_W-1:0]   next_ch;
    logic              has_next;
    logic              chan_done;

    // Clamp, lowest set bit of the incoming mask, and next higher set bit of
    // the latched mask above the current channel. Loops run downwards so the
    // last hit is the lowest qualifying index.
    always_comb begin
        eff_len  = (length > DEPTH_L) ? DEPTH_L : length;
        first_ch = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (ch_mask[i-1]) first_ch = CH_W'(i - 1);
        end
        next_ch  = '0;
        has_next = 1'b0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (mask_q[i-1] && ((i - 1) > 32'(ch_q))) begin
                next_ch  = CH_W'(i - 1);
                has_next = 1'b1;
            end
        end
        // len_q is never zero outside IDLE/FIN, so the subtraction is safe
        chan_done = ({1'b0, off_q} == (len_q - LEN_ONE));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (ch_mask == '0 || eff_len == '0) state_d = FIN;
                    else                                state_d = ISSUE;
                end
            end
            ISSUE: state_d = LOAD;
            LOAD:  state_d = SEND;
            SEND: begin
                if (out_ready) begin
                    if (chan_done && !has_next) state_d = FIN;
                    else                        state_d = ISSUE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides any handshake in the same cycle
        if (abort && state != IDLE) state_d = IDLE;

        busy      = (state != IDLE);
        done      = (state == FIN);
        out_valid = (state == SEND);
        mem_rd_en = '0;
        if (state == ISSUE) mem_rd_en[ch_q] = 1'b1;
        // ADDR_W-bit add wraps modulo DEPTH
        mem_addr  = base_q + off_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            ch_q     <= '0;
            off_q    <= '0;
            out_data <= '0;
            out_ch   <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= ch_mask;
                        base_q <= base_addr;
                        len_q  <= eff_len;
                        ch_q   <= first_ch;
                        off_q  <= '0;
                    end
                end
                LOAD: begin
                    out_data <= mem_rd_data[32'(ch_q)*DATA_W +: DATA_W];
                    out_ch   <= ch_q;
                    out_addr <= mem_addr;
                    out_last <= chan_done && !has_next;
                end
                SEND: begin
                    if (out_ready && !abort) begin
                        if (!chan_done) begin
                            off_q <= off_q + OFF_ONE;
                        end else if (has_next) begin
                            ch_q  <= next_ch;
                            off_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_ctrl
//   Directed bench for mem_dump_ctrl with two 1024-byte memories
//   (ch0[i] = i, ch1[i] = ~i) behind a one-cycle-latency read port.
// ---------------------------------------------------------------------------
module tb_mem_dump_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int NCH    = 2;
    localparam int CH_W   = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  abort;
    logic [NCH-1:0]        ch_mask;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W:0]       length;
    logic [NCH-1:0]        mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [NCH*DATA_W-1:0] mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [CH_W-1:0]       out_ch;
    logic [ADDR_W-1:0]     out_addr;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt0 = 0;
    int rd_cnt1 = 0;

    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];

    mem_dump_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NCH    (NCH),
        .CH_W   (CH_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .ch_mask     (ch_mask),
        .base_addr   (base_addr),
        .length      (length),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_addr    (out_addr),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Synchronous read memories, plus per-channel read strobe counters
    always @(posedge clk) begin
        if (mem_rd_en[0]) begin
            mem_rd_data[7:0] <= mem0[mem_addr];
            rd_cnt0          <= rd_cnt0 + 1;
        end
        if (mem_rd_en[1]) begin
            mem_rd_data[15:8] <= mem1[mem_addr];
            rd_cnt1           <= rd_cnt1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [9:0] b, input logic [10:0] l);
        ch_mask   = m;
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Called with the DUT in ISSUE: LOAD and SEND follow, so the byte shows
    // up after exactly two edges (3 cycles handshake to handshake).
    task automatic recv(input string tag, input int ech, input int eaddr,
                        input int edata, input int elast);
        int n;
        out_ready = 1'b1;
        wait_valid(n);
        check({tag, ".wait"},  32'(n),         32'(2));
        check({tag, ".valid"}, 32'(out_valid), 32'(1));
        check({tag, ".ch"},    32'(out_ch),    32'(ech));
        check({tag, ".addr"},  32'(out_addr),  32'(eaddr));
        check({tag, ".data"},  32'(out_data),  32'(edata));
        check({tag, ".last"},  32'(out_last),  32'(elast));
        tick();
    endtask

    task automatic fin_check(input string tag);
        check({tag, ".done"},   32'(done),      32'(1));
        check({tag, ".busy"},   32'(busy),      32'(1));
        check({tag, ".nvalid"}, 32'(out_valid), 32'(0));
        tick();
        check({tag, ".done_off"}, 32'(done), 32'(0));
        check({tag, ".idle"},     32'(busy), 32'(0));
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(0));
        check({tag, ".busy"},  32'(busy),      32'(0));
        check({tag, ".done"},  32'(done),      32'(0));
        check({tag, ".data"},  32'(out_data),  32'(0));
        check({tag, ".ch"},    32'(out_ch),    32'(0));
        check({tag, ".addr"},  32'(out_addr),  32'(0));
        check({tag, ".last"},  32'(out_last),  32'(0));
        check({tag, ".rden"},  32'(mem_rd_en), 32'(0));
        check({tag, ".maddr"}, 32'(mem_addr),  32'(0));
    endtask

    initial begin
        logic [7:0] t1_data [8];
        int r0, r1, n, errs;
        logic [9:0] a;
        logic [7:0] d;
        logic       c;

        t1_data = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = 8'(i);
            mem1[i] = ~8'(i);
        end

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        ch_mask   = '0;
        base_addr = '0;
        length    = '0;
        tick();
        tick();
        all_zero("rst");
        reset = 1'b0;
        tick();

        // 1: both channels, 4 bytes each
        do_start(2'b11, 10'd0, 11'd4);
        for (int k = 0; k < 8; k++)
            recv($sformatf("t1.b%0d", k), k / 4, k % 4, int'(t1_data[k]), (k == 7) ? 1 : 0);
        fin_check("t1.fin");

        // 2: single channel with address wrap
        r0 = rd_cnt0;
        r1 = rd_cnt1;
        do_start(2'b10, 10'd1022, 11'd4);
        recv("t2.b0", 1, 1022, 8'h01, 0);
        recv("t2.b1", 1, 1023, 8'h00, 0);
        recv("t2.b2", 1, 0,    8'hFF, 0);
        recv("t2.b3", 1, 1,    8'hFE, 1);
        fin_check("t2.fin");
        check("t2.rd0", 32'(rd_cnt0 - r0), 32'(0));
        check("t2.rd1", 32'(rd_cnt1 - r1), 32'(4));

        // 3: backpressure on the first byte
        do_start(2'b01, 10'd5, 11'd2);
        wait_valid(n);
        out_ready = 1'b0;
        r0 = rd_cnt0;
        r1 = rd_cnt1;
        for (int k = 0; k < 5; k++) tick();
        check("t3.valid", 32'(out_valid), 32'(1));
        check("t3.data",  32'(out_data),  32'h05);
        check("t3.addr",  32'(out_addr),  32'(5));
        check("t3.ch",    32'(out_ch),    32'(0));
        check("t3.last",  32'(out_last),  32'(0));
        check("t3.rd0",   32'(rd_cnt0 - r0), 32'(0));
        check("t3.rd1",   32'(rd_cnt1 - r1), 32'(0));
        out_ready = 1'b1;
        tick();
        recv("t3.b1", 0, 6, 8'h06, 1);
        fin_check("t3.fin");

        // 4: empty dumps finish straight through FIN
        r0 = rd_cnt0;
        r1 = rd_cnt1;
        do_start(2'b00, 10'd0, 11'd4);
        fin_check("t4.mask0");
        do_start(2'b11, 10'd0, 11'd0);
        fin_check("t4.len0");
        check("t4.rd0", 32'(rd_cnt0 - r0), 32'(0));
        check("t4.rd1", 32'(rd_cnt1 - r1), 32'(0));

        // 4c: length 2000 clamps to 1024 per channel, wrapping from base 512
        r0 = rd_cnt0;
        r1 = rd_cnt1;
        errs = 0;
        do_start(2'b11, 10'd512, 11'd2000);
        for (int k = 0; k < 2048; k++) begin
            c = (k >= 1024);
            a = 10'(512 + (k % 1024));
            d = c ? ~8'(a) : 8'(a);
            wait_valid(n);
            if (n != 2 || out_valid !== 1'b1 || out_ch !== c || out_addr !== a ||
                out_data !== d || out_last !== (k == 2047))
                errs++;
            tick();
        end
        check("t4.clamp_errs", 32'(errs), 32'(0));
        check("t4.clamp_rd0", 32'(rd_cnt0 - r0), 32'(1024));
        check("t4.clamp_rd1", 32'(rd_cnt1 - r1), 32'(1024));
        fin_check("t4.clamp_fin");

        // 5: abort with a simultaneous handshake on the third byte
        do_start(2'b11, 10'd0, 11'd4);
        recv("t5.b0", 0, 0, 8'h00, 0);
        recv("t5.b1", 0, 1, 8'h01, 0);
        wait_valid(n);
        check("t5.b2.addr", 32'(out_addr), 32'(2));
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        check("t5.valid", 32'(out_valid), 32'(0));
        check("t5.busy",  32'(busy),      32'(0));
        check("t5.done",  32'(done),      32'(0));
        r0 = rd_cnt0;
        r1 = rd_cnt1;
        tick();
        tick();
        tick();
        check("t5.done_late", 32'(done), 32'(0));
        check("t5.rd0", 32'(rd_cnt0 - r0), 32'(0));
        check("t5.rd1", 32'(rd_cnt1 - r1), 32'(0));
        do_start(2'b01, 10'd0, 11'd2);
        recv("t5.r0", 0, 0, 8'h00, 0);
        recv("t5.r1", 0, 1, 8'h01, 1);
        fin_check("t5.fin");

        // 6a: start while busy is ignored
        r1 = rd_cnt1;
        do_start(2'b01, 10'd10, 11'd3);
        recv("t6.b0", 0, 10, 8'h0A, 0);
        ch_mask   = 2'b10;
        base_addr = 10'd100;
        length    = 11'd1;
        start     = 1'b1;
        recv("t6.b1", 0, 11, 8'h0B, 0);
        start = 1'b0;
        recv("t6.b2", 0, 12, 8'h0C, 1);
        fin_check("t6.fin");
        check("t6.rd1", 32'(rd_cnt1 - r1), 32'(0));

        // 6b: synchronous reset mid-dump
        do_start(2'b11, 10'd0, 11'd4);
        recv("t6.r0", 0, 0, 8'h00, 0);
        wait_valid(n);
        check("t6.pre_valid", 32'(out_valid), 32'(1));
        reset = 1'b1;
        tick();
        all_zero("t6.rst");
        reset = 1'b0;
        tick();
        check("t6.rst_done", 32'(done), 32'(0));
        check("t6.rst_busy", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
